if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch stage of core_lapido. It is the consumer of the MEM stage's branch resolution outputs (branch_taken, branch_addr).
- Owns the PC and drives a variable-latency instruction-memory request/ready handshake.
- Loads the IF/ID pipeline register that feeds decode.
- Handles hazard-unit stalls with a one-entry skid buffer.
- Handles MEM-stage redirects, including discarding an in-flight fetch.

Parameters:
PC_WIDTH, 32, width of PC, branch target and next-PC fields (matches lapido_defs PC_WIDTH)
INSTR_WIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset
NOP_INSTR, 0, instruction word presented while IF/ID holds a bubble

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
stall  input  1  hazard unit: hold IF/ID and PC
branch_taken  input  1  MEM stage: redirect fetch this cycle
branch_addr  input  PC_WIDTH  MEM stage: redirect target
imem_req  output  1  fetch request valid
imem_addr  output  PC_WIDTH  word address of fetch; stable while imem_req=1 and imem_ready=0
imem_ready  input  1  memory returns imem_rdata this cycle (only meaningful while imem_req=1)
imem_rdata  input  INSTR_WIDTH  fetched word
out_valid  output  1  IF/ID holds a real instruction
out_instr  output  INSTR_WIDTH  IF/ID instruction
out_next_pc  output  PC_WIDTH  IF/ID PC+1 of that instruction

Behaviour:
- Reset values (asynchronous, active-high, while rst=1):
  - pc=RESET_PC, req_addr=RESET_PC, state=S_IDLE.
  - imem_req=0, out_valid=0, out_instr=NOP_INSTR, out_next_pc=0.
  - Skid buffer empty.
- Addressing: word-addressed; next sequential PC = pc+1, wraps modulo 2^PC_WIDTH (all-ones -> 0).
- imem_addr = req_addr register; it changes only when a new request begins.
- States:
  - S_IDLE: one cycle after reset release -> S_REQ; req_addr<=pc.
  - S_REQ: imem_req=1.
    - imem_ready=1, no stall, no branch: IF/ID<={valid=1, imem_rdata, pc+1}; pc<=pc+1; req_addr<=pc+1; stay S_REQ. Back-to-back fetch, one instruction per cycle when memory is zero-wait.
    - imem_ready=0, no stall: out_valid<=0 (bubble inserted), IF/ID payload unchanged.
    - stall=1, imem_ready=1: IF/ID held; word latched into skid buffer with pc+1; pc<=pc+1; -> S_HOLD (imem_req=0).
    - stall=1, imem_ready=0: IF/ID held, request stays outstanding.
  - S_HOLD: imem_req=0.
    - When stall=0: IF/ID<=buffer (valid=1); buffer emptied; req_addr<=pc; -> S_REQ.
  - S_KILL: imem_req=1 at the stale req_addr until imem_ready.
    - Returned data is discarded; out_valid stays 0.
    - On imem_ready: req_addr<=pc; -> S_REQ.
- Branch (branch_taken=1) has priority over stall and over imem_ready data:
  - pc<=branch_addr; out_valid<=0; skid buffer cleared.
  - From S_REQ with imem_ready=0 -> S_KILL (the in-flight request is never aborted).
  - From S_REQ with imem_ready=1, or from S_HOLD/S_IDLE -> S_REQ with req_addr<=branch_addr.
  - Branch while in S_KILL: pc overwritten with the new target; remains S_KILL.
- Latency: zero-wait memory gives a redirect-to-valid-IF/ID latency of 2 cycles.
- Reset mid-fetch: state returns to S_IDLE immediately. Any later imem_ready for the old request is ignored, because imem_req=0.

Decomposition:
- lapido_defs.v gains:
  - state encodings IF_S_IDLE, IF_S_REQ, IF_S_HOLD, IF_S_KILL (2 bits);
  - NOP instruction constant;
  - RESET_PC constant.
- One natural sub-module: if_id_reg, holding the IF/ID register with load/hold/bubble controls. The FSM, PC and skid buffer stay in if_stage.

Test Plan:
1. Reset release, imem_ready tied 1, rdata=addr+0x100 -> imem_addr 0,1,2,3 on consecutive cycles; out_instr 0x100,0x101,0x102 with out_next_pc 1,2,3, out_valid=1 each cycle.
2. Memory ready after 3 cycles per fetch -> imem_addr stable 3 cycles; out_valid pulses once per 3 cycles; no address skipped.
3. stall=1 for 4 cycles while ready=1 at addr 5 -> IF/ID holds addr-4 instruction, S_HOLD with imem_req=0; after stall drops, word for addr 5 appears with out_next_pc=6, then fetch of 6.
4. branch_taken with branch_addr=0x40 while addr 7 is outstanding (ready=0) -> out_valid=0, imem_addr stays 7 until ready; that data is discarded; next request is 0x40 and the next valid out_instr is from 0x40.
5. branch_taken and stall asserted in the same cycle, with ready=1 -> branch wins: out_valid=0, next imem_addr=branch_addr.
6. PC at 0xFFFFFFFF fetched, then rst asserted mid-request with ready=0 -> wrap check shows out_next_pc=0; rst forces imem_req=0, out_valid=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the core_lapido instruction-fetch stage:
// default widths and constants, FSM state encoding, IF/ID register controls.
package if_stage_pkg;

    localparam int          IF_PC_WIDTH    = 32;
    localparam int          IF_INSTR_WIDTH = 32;
    localparam logic [31:0] IF_RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] IF_NOP_INSTR   = 32'h0000_0000;

    // Fetch FSM states (2-bit encoding shared with lapido_defs).
    typedef enum logic [1:0] {
        IF_S_IDLE = 2'd0,   // first cycle after reset release
        IF_S_REQ  = 2'd1,   // request outstanding at req_addr
        IF_S_HOLD = 2'd2,   // stalled with a fetched word parked in the skid buffer
        IF_S_KILL = 2'd3    // wrong-path request still outstanding, data will be dropped
    } if_state_t;

    // What the IF/ID register does on the next rising edge.
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0, // keep valid and payload
        IFID_LOAD   = 2'd1, // capture a new instruction, valid=1
        IFID_BUBBLE = 2'd2  // valid=0, payload unchanged
    } ifid_op_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage and memory.
interface if_stage_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ready;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    // Fetch stage side: issues requests, receives data.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    // Memory side: accepts requests, returns data.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold or bubble under control of the fetch FSM.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int                     PC_WIDTH    = IF_PC_WIDTH,
    parameter int                     INSTR_WIDTH = IF_INSTR_WIDTH,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(IF_NOP_INSTR)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  ifid_op_t               i_op,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [PC_WIDTH-1:0]    i_next_pc,
    output logic                   o_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [PC_WIDTH-1:0]    o_next_pc
);

    logic                   r_valid;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]    r_next_pc;

    // Update the register; a bubble only clears valid so decode sees a stable payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_instr   <= NOP_INSTR;
            r_next_pc <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (i_op)
                IFID_LOAD: begin
                    r_valid   <= 1'b1;
                    r_instr   <= i_instr;
                    r_next_pc <= i_next_pc;
                end
                IFID_BUBBLE: r_valid <= 1'b0;
                default:     ;
            endcase
        end
    end

    // While the register holds a bubble the stage presents the NOP word.
    assign o_valid   = r_valid;
    assign o_instr   = r_valid ? r_instr : NOP_INSTR;
    assign o_next_pc = r_next_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage of core_lapido: PC, fetch FSM, one-entry skid buffer,
// MEM-stage redirect handling, and the IF/ID register feeding decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                     PC_WIDTH    = IF_PC_WIDTH,
    parameter int                     INSTR_WIDTH = IF_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = PC_WIDTH'(IF_RESET_PC),
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(IF_NOP_INSTR)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_addr,
    if_stage_if.master             imem,
    output logic                   out_valid,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]    out_next_pc
);

    if_state_t              r_state,        w_state_next;
    logic [PC_WIDTH-1:0]    r_pc,           w_pc_next;
    logic [PC_WIDTH-1:0]    r_req_addr,     w_req_addr_next;
    logic [INSTR_WIDTH-1:0] r_skid_instr,   w_skid_instr_next;
    logic [PC_WIDTH-1:0]    r_skid_next_pc, w_skid_next_pc_next;
    logic [PC_WIDTH-1:0]    w_pc_inc;
    logic                   w_imem_req;
    ifid_op_t               w_ifid_op;
    logic [INSTR_WIDTH-1:0] w_ifid_instr;
    logic [PC_WIDTH-1:0]    w_ifid_next_pc;

    // Sequential PC wraps naturally modulo 2^PC_WIDTH.
    assign w_pc_inc = r_pc + PC_WIDTH'(1);

    // Next-state, PC, request address, skid buffer and IF/ID control.
    // The skid buffer is full exactly while in IF_S_HOLD; leaving HOLD empties it.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_state_next        = r_state;
        w_pc_next           = r_pc;
        w_req_addr_next     = r_req_addr;
        w_skid_instr_next   = r_skid_instr;
        w_skid_next_pc_next = r_skid_next_pc;
        w_imem_req          = 1'b0;
        w_ifid_op           = IFID_HOLD;
        w_ifid_instr        = imem.imem_rdata;
        w_ifid_next_pc      = w_pc_inc;

        // A redirect beats stall and returned data in every state.
        if (branch_taken) begin
            w_pc_next = branch_addr;
            w_ifid_op = IFID_BUBBLE;
        end

        case (r_state)
            IF_S_IDLE: begin
                w_state_next    = IF_S_REQ;
                w_req_addr_next = branch_taken ? branch_addr : r_pc;
            end

            IF_S_REQ: begin
                w_imem_req = 1'b1;
                if (branch_taken) begin
                    // An in-flight request is never aborted; drain it in KILL.
                    if (imem.imem_ready) w_req_addr_next = branch_addr;
                    else                 w_state_next    = IF_S_KILL;
                end else if (stall) begin
                    if (imem.imem_ready) begin
                        w_skid_instr_next   = imem.imem_rdata;
                        w_skid_next_pc_next = w_pc_inc;
                        w_pc_next           = w_pc_inc;
                        w_state_next        = IF_S_HOLD;
                    end
                end else if (imem.imem_ready) begin
                    w_ifid_op       = IFID_LOAD;
                    w_pc_next       = w_pc_inc;
                    w_req_addr_next = w_pc_inc;
                end else begin
                    w_ifid_op = IFID_BUBBLE;
                end
            end

            IF_S_HOLD: begin
                if (branch_taken) begin
                    w_req_addr_next = branch_addr;
                    w_state_next    = IF_S_REQ;
                end else if (!stall) begin
                    w_ifid_op       = IFID_LOAD;
                    w_ifid_instr    = r_skid_instr;
                    w_ifid_next_pc  = r_skid_next_pc;
                    w_req_addr_next = r_pc;
                    w_state_next    = IF_S_REQ;
                end
            end

            IF_S_KILL: begin
                // Keep the stale request up until memory answers, then drop the data.
                w_imem_req = 1'b1;
                if (imem.imem_ready) begin
                    w_req_addr_next = branch_taken ? branch_addr : r_pc;
                    w_state_next    = IF_S_REQ;
                end
            end

            default: w_state_next = IF_S_IDLE;
        endcase
    end

    // State, PC, request address and skid buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IF_S_IDLE;
            r_pc           <= RESET_PC;
            r_req_addr     <= RESET_PC;
            r_skid_instr   <= NOP_INSTR;
            r_skid_next_pc <= '0;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_req_addr     <= w_req_addr_next;
            r_skid_instr   <= w_skid_instr_next;
            r_skid_next_pc <= w_skid_next_pc_next;
        end
    end

    assign imem.imem_req  = w_imem_req;
    assign imem.imem_addr = r_req_addr;

    if_id_reg #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH),
        .NOP_INSTR   (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .i_op      (w_ifid_op),
        .i_instr   (w_ifid_instr),
        .i_next_pc (w_ifid_next_pc),
        .o_valid   (out_valid),
        .o_instr   (out_instr),
        .o_next_pc (out_next_pc)
    );

endmodule
